// File: rtl/md_iter_unit_pkg.sv
// Shared encodings for the multiply/divide unit: md_op codes, FSM states,
// and small op-class helpers.
package md_iter_unit_pkg;

  typedef enum logic [3:0] {
    md_none  = 4'd0,
    mult_md  = 4'd1,
    multu_md = 4'd2,
    div_md   = 4'd3,
    divu_md  = 4'd4,
    madd_md  = 4'd5,
    maddu_md = 4'd6,
    msub_md  = 4'd7,
    msubu_md = 4'd8,
    mthi_md  = 4'd9,
    mtlo_md  = 4'd10
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return op inside {mult_md, multu_md, madd_md, maddu_md, msub_md, msubu_md};
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op inside {div_md, divu_md};
  endfunction

endpackage

// File: rtl/md_iter_unit_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
interface md_iter_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       md_op;
  logic             cancel;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, cancel, rs_val, rt_val,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, cancel, rs_val, rt_val,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_iter_unit_div_core.sv
// Unsigned restoring divider: one quotient bit per step, WIDTH steps after load.
module md_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);
  localparam int SW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [SW-1:0]    steps_q, steps_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  assign done      = (steps_q == SW'(WIDTH));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  // quo_q doubles as the dividend shift register; its MSB feeds the remainder.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    steps_d = steps_q;
    trial   = {rem_q, quo_q[WIDTH-1]};
    diff    = trial - {1'b0, dvs_q};
    if (load) begin
      rem_d   = '0;
      quo_d   = dividend;
      dvs_d   = divisor;
      steps_d = '0;
    end else if (step && !done) begin
      if (diff[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end
      steps_d = steps_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      steps_q <= '0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      steps_q <= steps_d;
    end
  end
endmodule

// File: rtl/md_iter_unit.sv
// Iterative multiply/divide unit owning HI/LO: fixed-latency multiply and MAC,
// restoring divide with sign fix-up, exception cancel.
module md_iter_unit
  import md_iter_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input logic           clk,
  input logic           reset,
  md_iter_unit_if.slave md
);
  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0]   div_a_q, div_a_d;
  logic               div_signed_q, div_signed_d;
  logic               div_qneg_q, div_qneg_d;
  logic               div_bzero_q, div_bzero_d;
  logic               div_ovf_q, div_ovf_d;

  logic               accept;
  logic               op_mul, op_div;
  logic               a_neg, b_neg, sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] hilo, prod_s, prod_u, mul_res;
  logic [WIDTH-1:0]   div_quo, div_rem;
  logic               div_done, div_load, div_step, rneg;

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

  assign accept = md.start && !busy_q && !md.cancel;
  assign op_mul = is_mul_op(md.md_op);
  assign op_div = is_div_op(md.md_op);
  assign hilo   = {hi_q, lo_q};

  // Explicit extension keeps the low 2*WIDTH product bits correct for both signednesses.
  assign prod_s = {{WIDTH{md.rs_val[WIDTH-1]}}, md.rs_val} * {{WIDTH{md.rt_val[WIDTH-1]}}, md.rt_val};
  assign prod_u = {{WIDTH{1'b0}}, md.rs_val} * {{WIDTH{1'b0}}, md.rt_val};

  assign sgn   = (md.md_op == div_md);
  assign a_neg = sgn && md.rs_val[WIDTH-1];
  assign b_neg = sgn && md.rt_val[WIDTH-1];
  assign a_mag = a_neg ? -md.rs_val : md.rs_val;
  assign b_mag = b_neg ? -md.rt_val : md.rt_val;
  assign rneg  = div_signed_q && div_a_q[WIDTH-1];

  assign div_load = accept && op_div;
  assign div_step = (state_q == DIV);

  md_div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk      (clk),
    .reset    (reset),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quotient (div_quo),
    .remainder(div_rem),
    .done     (div_done)
  );

  always_comb begin
    mul_res = '0;
    case (md.md_op)
      mult_md:  mul_res = prod_s;
      multu_md: mul_res = prod_u;
      madd_md:  mul_res = hilo + prod_s;
      maddu_md: mul_res = hilo + prod_u;
      msub_md:  mul_res = hilo - prod_s;
      msubu_md: mul_res = hilo - prod_u;
      default:  mul_res = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    res_d        = res_q;
    div_a_d      = div_a_q;
    div_signed_d = div_signed_q;
    div_qneg_d   = div_qneg_q;
    div_bzero_d  = div_bzero_q;
    div_ovf_d    = div_ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_mul) begin
            res_d   = mul_res;
            cnt_d   = CW'(MUL_LAT);
            state_d = MUL;
          end else if (op_div) begin
            div_a_d      = md.rs_val;
            div_signed_d = sgn;
            div_qneg_d   = a_neg ^ b_neg;
            div_bzero_d  = (md.rt_val == '0);
            div_ovf_d    = sgn && (md.rs_val == INT_MIN) && (md.rt_val == ALL_ONES);
            cnt_d        = CW'(WIDTH);
            state_d      = DIV;
          end else if (md.md_op == mthi_md) begin
            hi_d = md.rs_val;
          end else if (md.md_op == mtlo_md) begin
            lo_d = md.rs_val;
          end
        end
      end
      MUL: begin
        if (md.cancel) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CW'(1)) begin
          {hi_d, lo_d} = res_q;
          cnt_d        = '0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV: begin
        if (md.cancel) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        if (md.cancel) begin
          state_d = IDLE;
        end else if (div_done) begin
          if (div_bzero_q) begin
            hi_d = div_a_q;
            lo_d = rneg ? WIDTH'(1) : ALL_ONES;
          end else if (div_ovf_q) begin
            hi_d = '0;
            lo_d = INT_MIN;
          end else begin
            hi_d = rneg ? -div_rem : div_rem;
            lo_d = div_qneg_q ? -div_quo : div_quo;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      res_q        <= '0;
      div_a_q      <= '0;
      div_signed_q <= 1'b0;
      div_qneg_q   <= 1'b0;
      div_bzero_q  <= 1'b0;
      div_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      res_q        <= res_d;
      div_a_q      <= div_a_d;
      div_signed_q <= div_signed_d;
      div_qneg_q   <= div_qneg_d;
      div_bzero_q  <= div_bzero_d;
      div_ovf_q    <= div_ovf_d;
    end
  end
endmodule
